pll_lock_sequencer: RTL

//  Sequences the 50->100 MHz PLL: holds PLL reset for a minimum time, waits for lock with timeout,

---
 rtl/pll_lock_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pll_lock_sequencer                                              |
// | Brief    : PLL reset/lock sequencer with timeout, lock debounce, retry     |
// |            limit and sticky fault. Optional macro PLL_SEQ_LOSS_CNT_EN adds  |
// |            the loss_cnt output (RUN->FAIL transition counter).             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES     = 7,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        fault_clr,
  output logic        pll_rst,
  output logic        sys_rst_n,
  output logic        lock_ok,
  output logic        fault,
  output logic [7:0]  retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0] loss_cnt
`endif
);

  localparam int unsigned c_cnt_max =
    (RST_CYCLES > LOCK_TIMEOUT) ?
      ((RST_CYCLES > DEBOUNCE_CYCLES) ? RST_CYCLES : DEBOUNCE_CYCLES) :
      ((LOCK_TIMEOUT > DEBOUNCE_CYCLES) ? LOCK_TIMEOUT : DEBOUNCE_CYCLES);
  localparam int unsigned c_cnt_w = (c_cnt_max < 2) ? 1 : $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [7:0]         c_max_retries = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_DEBOUNCE  = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_cnt_w-1:0]       w_cnt_nxt;
  logic [7:0]               r_retry;
  logic [7:0]               w_retry_nxt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_lk_s;
  logic                     r_pll_rst;
  logic                     r_sys_rst_n;
  logic                     r_lock_ok;
  logic                     r_fault;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lk_s = r_sync[SYNC_STAGES-1];

  // Lock sampled in the timeout cycle takes priority over the timeout itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == c_rst_last) w_state_nxt = S_WAIT_LOCK;
        else                     w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_WAIT_LOCK: begin
        if (w_lk_s)                   w_state_nxt = S_DEBOUNCE;
        else if (r_cnt == c_tmo_last) w_state_nxt = S_FAIL;
        else                          w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_DEBOUNCE: begin
        if (!w_lk_s)                  w_state_nxt = S_FAIL;
        else if (r_cnt == c_deb_last) w_state_nxt = S_RUN;
        else                          w_cnt_nxt   = r_cnt + c_cnt_one;
      end
      S_RUN: begin
        if (!w_lk_s) w_state_nxt = S_FAIL;
      end
      S_FAIL: begin
        if (r_retry > c_max_retries) w_state_nxt = S_FAULT;
        else                         w_state_nxt = S_HOLD;
      end
      S_FAULT: begin
        if (fault_clr) w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    w_retry_nxt = r_retry;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        S_FAIL: if (r_retry != 8'hFF) w_retry_nxt = r_retry + 8'd1;
        S_RUN:  w_retry_nxt = '0;
        S_HOLD: if (r_state == S_FAULT) w_retry_nxt = '0;
        default: w_retry_nxt = r_retry;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_ok   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_FAIL) ||
                     (w_state_nxt == S_FAULT);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_lock_ok   <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign lock_ok   = r_lock_ok;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if ((r_state == S_RUN) && (w_state_nxt == S_FAIL) && (r_loss_cnt != 16'hFFFF)) begin
      r_loss_cnt <= r_loss_cnt + 16'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire
